// File: rtl/imm_gen_pipe_if.sv
// rtl/imm_gen_pipe_if.sv - instruction-in / immediate-out handshake bundle for imm_gen_pipe
// Optional ill_cnt/ill_seen exist only when IMM_GEN_ILLEGAL_TRAP_EN is defined.
interface imm_gen_pipe_if #(
    parameter int XLEN = 64
);
    logic            in_valid;
    logic            in_ready;
    logic [31:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_imm;
    logic [2:0]      out_fmt;
    logic [31:0]     out_instr;
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
    logic [15:0]     ill_cnt;
    logic            ill_seen;
`endif

    modport master (
        output in_valid,
        output in_instr,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_imm,
        input  out_fmt,
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
        input  ill_cnt,
        input  ill_seen,
`endif
        input  out_instr
    );

    modport slave (
        input  in_valid,
        input  in_instr,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_imm,
        output out_fmt,
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
        output ill_cnt,
        output ill_seen,
`endif
        output out_instr
    );
endinterface

// File: rtl/imm_gen_pipe.sv
// rtl/imm_gen_pipe.sv - registered RV immediate generator with 2-entry skid buffer
// Optional macro IMM_GEN_ILLEGAL_TRAP_EN adds the illegal-opcode counter and sticky flag.
module imm_gen_pipe #(
    parameter int XLEN = 64
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    imm_gen_pipe_if.slave bus
);
    generate
        if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
            $error("imm_gen_pipe: XLEN must be 32 or 64");
        end
    endgenerate

    localparam logic [2:0] FMT_R   = 3'd0;
    localparam logic [2:0] FMT_I   = 3'd1;
    localparam logic [2:0] FMT_S   = 3'd2;
    localparam logic [2:0] FMT_B   = 3'd3;
    localparam logic [2:0] FMT_U   = 3'd4;
    localparam logic [2:0] FMT_J   = 3'd5;
    localparam logic [2:0] FMT_ILL = 3'd7;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_TWO   = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            in_ready_q;
    logic            out_valid_q;
    logic [XLEN-1:0] out_imm_q,   skid_imm_q;
    logic [2:0]      out_fmt_q,   skid_fmt_q;
    logic [31:0]     out_instr_q, skid_instr_q;

    logic [31:0]     ins;
    logic [31:0]     imm32;
    logic [2:0]      dec_fmt;
    logic [XLEN-1:0] dec_imm;

    // Decode happens on the way in, so both storage slots hold finished results.
    always_comb begin
        ins     = bus.in_instr;
        imm32   = 32'd0;
        dec_fmt = FMT_ILL;
        case (ins[6:0])
            7'b0010011, 7'b0000011, 7'b1100111, 7'b0011011, 7'b1110011: begin
                dec_fmt = FMT_I;
                imm32   = {{20{ins[31]}}, ins[31:20]};
            end
            7'b0100011: begin
                dec_fmt = FMT_S;
                imm32   = {{20{ins[31]}}, ins[31:25], ins[11:7]};
            end
            7'b1100011: begin
                dec_fmt = FMT_B;
                imm32   = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
            end
            7'b0110111, 7'b0010111: begin
                dec_fmt = FMT_U;
                imm32   = {ins[31:12], 12'd0};
            end
            7'b1101111: begin
                dec_fmt = FMT_J;
                imm32   = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
            end
            7'b0110011, 7'b0111011: begin
                dec_fmt = FMT_R;
                imm32   = 32'd0;
            end
            default: begin
                dec_fmt = FMT_ILL;
                imm32   = 32'd0;
            end
        endcase
        dec_imm = XLEN'($signed(imm32));
    end

    logic accept, drain;
    logic load_out_new, load_out_skid, load_skid;

    assign accept = bus.in_valid && in_ready_q;
    assign drain  = out_valid_q && bus.out_ready;

    always_comb begin
        state_d       = state_q;
        load_out_new  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (flush) begin
            state_d = ST_EMPTY;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept) begin
                        state_d      = ST_ONE;
                        load_out_new = 1'b1;
                    end
                end
                ST_ONE: begin
                    if (accept && !drain) begin
                        state_d   = ST_TWO;
                        load_skid = 1'b1;
                    end else if (accept && drain) begin
                        load_out_new = 1'b1;
                    end else if (drain) begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_TWO: begin
                    if (drain) begin
                        state_d       = ST_ONE;
                        load_out_skid = 1'b1;
                    end
                end
                default: state_d = ST_EMPTY;
            endcase
        end
    end

    // in_ready and out_valid are flops so nothing downstream reaches upstream combinationally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            out_imm_q    <= '0;
            out_fmt_q    <= FMT_R;
            out_instr_q  <= 32'd0;
            skid_imm_q   <= '0;
            skid_fmt_q   <= FMT_R;
            skid_instr_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= (state_d != ST_TWO);
            out_valid_q <= (state_d != ST_EMPTY);
            if (load_out_new) begin
                out_imm_q   <= dec_imm;
                out_fmt_q   <= dec_fmt;
                out_instr_q <= bus.in_instr;
            end else if (load_out_skid) begin
                out_imm_q   <= skid_imm_q;
                out_fmt_q   <= skid_fmt_q;
                out_instr_q <= skid_instr_q;
            end
            if (load_skid) begin
                skid_imm_q   <= dec_imm;
                skid_fmt_q   <= dec_fmt;
                skid_instr_q <= bus.in_instr;
            end
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_imm   = out_imm_q;
    assign bus.out_fmt   = out_fmt_q;
    assign bus.out_instr = out_instr_q;

`ifdef IMM_GEN_ILLEGAL_TRAP_EN
    logic [15:0] ill_cnt_q;
    logic        ill_seen_q;

    // Counts illegal entries as they leave; survives flush, saturates at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ill_cnt_q  <= 16'd0;
            ill_seen_q <= 1'b0;
        end else if (drain && out_fmt_q == FMT_ILL) begin
            if (ill_cnt_q != 16'hFFFF) begin
                ill_cnt_q <= ill_cnt_q + 16'd1;
            end
            ill_seen_q <= 1'b1;
        end
    end

    assign bus.ill_cnt  = ill_cnt_q;
    assign bus.ill_seen = ill_seen_q;
`else
    // Illegal opcodes still report fmt=7; no accounting is built.
`endif
endmodule

// File: tb/tb_imm_gen_pipe.sv
// tb/tb_imm_gen_pipe.sv - directed self-checking bench for imm_gen_pipe (XLEN=64)
module tb_imm_gen_pipe;
    localparam int XLEN = 64;

    logic clk;
    logic rst_n;
    logic flush;
    int   n_cmp;
    int   n_mis;

    imm_gen_pipe_if #(.XLEN(XLEN)) bus ();

    imm_gen_pipe #(.XLEN(XLEN)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        flush = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_instr  = 32'd0;
        bus.out_ready = 1'b0;
        repeat (3) step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL reset_out_valid: got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL reset_in_ready: got %0h exp 1", bus.in_ready); end
        n_cmp++; if (bus.out_imm !== 64'd0) begin n_mis++; $display("FAIL reset_out_imm: got %0h exp 0", bus.out_imm); end
        n_cmp++; if (bus.out_fmt !== 3'd0) begin n_mis++; $display("FAIL reset_out_fmt: got %0h exp 0", bus.out_fmt); end
        n_cmp++; if (bus.out_instr !== 32'd0) begin n_mis++; $display("FAIL reset_out_instr: got %0h exp 0", bus.out_instr); end
        rst_n = 1'b1;
        step();
    endtask

    task automatic test_addi();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'hFFF00093;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL addi_valid: got %0h exp 1", bus.out_valid); end
        n_cmp++; if (bus.out_imm !== 64'hFFFF_FFFF_FFFF_FFFF) begin n_mis++; $display("FAIL addi_imm: got %0h exp ffffffffffffffff", bus.out_imm); end
        n_cmp++; if (bus.out_fmt !== 3'd1) begin n_mis++; $display("FAIL addi_fmt: got %0h exp 1", bus.out_fmt); end
        n_cmp++; if (bus.out_instr !== 32'hFFF00093) begin n_mis++; $display("FAIL addi_instr: got %0h exp fff00093", bus.out_instr); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL addi_drained: got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] vin  [7];
        logic [63:0] vimm [7];
        logic [2:0]  vfmt [7];
        vin[0] = 32'h0020A423; vimm[0] = 64'h8;                    vfmt[0] = 3'd2;
        vin[1] = 32'hFE000EE3; vimm[1] = 64'hFFFF_FFFF_FFFF_FFFC;  vfmt[1] = 3'd3;
        vin[2] = 32'h123452B7; vimm[2] = 64'h1234_5000;            vfmt[2] = 3'd4;
        vin[3] = 32'h001000EF; vimm[3] = 64'h800;                  vfmt[3] = 3'd5;
        vin[4] = 32'h002081B3; vimm[4] = 64'h0;                    vfmt[4] = 3'd0;
        vin[5] = 32'h0000007F; vimm[5] = 64'h0;                    vfmt[5] = 3'd7;
        vin[6] = 32'hFFFFF0B7; vimm[6] = 64'hFFFF_FFFF_FFFF_F000;  vfmt[6] = 3'd4;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bus.in_valid = 1'b1;
            bus.in_instr = vin[i];
            step();
            n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL b2b_in_ready[%0d]: got %0h exp 1", i, bus.in_ready); end
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL b2b_valid[%0d]: got %0h exp 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_instr !== vin[i]) begin n_mis++; $display("FAIL b2b_instr[%0d]: got %0h exp %0h", i, bus.out_instr, vin[i]); end
            n_cmp++; if (bus.out_imm !== vimm[i]) begin n_mis++; $display("FAIL b2b_imm[%0d]: got %0h exp %0h", i, bus.out_imm, vimm[i]); end
            n_cmp++; if (bus.out_fmt !== vfmt[i]) begin n_mis++; $display("FAIL b2b_fmt[%0d]: got %0h exp %0h", i, bus.out_fmt, vfmt[i]); end
        end
        bus.in_valid = 1'b0;
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL b2b_drained: got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00500093;
        step();
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_one: got %0h exp 1", bus.in_ready); end
        bus.in_instr = 32'h0020A423;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_ready_two: got %0h exp 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_hold_valid[%0d]: got %0h exp 1", i, bus.out_valid); end
            n_cmp++; if (bus.out_instr !== 32'h00500093) begin n_mis++; $display("FAIL bp_hold_instr[%0d]: got %0h exp 00500093", i, bus.out_instr); end
            n_cmp++; if (bus.out_imm !== 64'h5) begin n_mis++; $display("FAIL bp_hold_imm[%0d]: got %0h exp 5", i, bus.out_imm); end
            n_cmp++; if (bus.in_ready !== 1'b0) begin n_mis++; $display("FAIL bp_hold_ready[%0d]: got %0h exp 0", i, bus.in_ready); end
            step();
        end
        bus.out_ready = 1'b1;
        step();
        n_cmp++; if (bus.out_instr !== 32'h0020A423) begin n_mis++; $display("FAIL bp_b_instr: got %0h exp 0020a423", bus.out_instr); end
        n_cmp++; if (bus.out_imm !== 64'h8) begin n_mis++; $display("FAIL bp_b_imm: got %0h exp 8", bus.out_imm); end
        n_cmp++; if (bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL bp_b_valid: got %0h exp 1", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL bp_ready_back: got %0h exp 1", bus.in_ready); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL bp_drained: got %0h exp 0", bus.out_valid); end
    endtask

    task automatic test_flush();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00500093;
        step();
        bus.in_instr  = 32'h0020A423;
        step();
        bus.in_instr  = 32'h123452B7;
        flush = 1'b1;
        step();
        flush = 1'b0;
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_valid: got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL flush_ready: got %0h exp 1", bus.in_ready); end
        bus.out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL flush_ghost[%0d]: got %0h exp 0", i, bus.out_valid); end
        end
        bus.in_valid = 1'b1;
        bus.in_instr = 32'h001000EF;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_instr !== 32'h001000EF || bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL flush_after: got %0h/%0h exp 001000ef/1", bus.out_instr, bus.out_valid); end
        step();
    endtask

    task automatic test_async_reset();
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h00500093;
        step();
        bus.in_instr  = 32'h0020A423;
        step();
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL arst_valid: got %0h exp 0", bus.out_valid); end
        n_cmp++; if (bus.in_ready !== 1'b1) begin n_mis++; $display("FAIL arst_ready: got %0h exp 1", bus.in_ready); end
        n_cmp++; if (bus.out_instr !== 32'd0 || bus.out_imm !== 64'd0 || bus.out_fmt !== 3'd0) begin n_mis++; $display("FAIL arst_fields: got %0h/%0h/%0h exp 0/0/0", bus.out_instr, bus.out_imm, bus.out_fmt); end
        #2;
        rst_n = 1'b1;
        step();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h123452B7;
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_instr !== 32'h123452B7 || bus.out_valid !== 1'b1) begin n_mis++; $display("FAIL arst_first: got %0h/%0h exp 123452b7/1", bus.out_instr, bus.out_valid); end
        step();
        n_cmp++; if (bus.out_valid !== 1'b0) begin n_mis++; $display("FAIL arst_no_stale: got %0h exp 0", bus.out_valid); end
    endtask

`ifdef IMM_GEN_ILLEGAL_TRAP_EN
    task automatic test_illegal();
        bus.out_ready = 1'b1;
        bus.in_valid  = 1'b1;
        bus.in_instr  = 32'h0000007F;
        step();
        n_cmp++; if (bus.out_fmt !== 3'd7 || bus.out_imm !== 64'd0) begin n_mis++; $display("FAIL ill_first: got %0h/%0h exp 7/0", bus.out_fmt, bus.out_imm); end
        n_cmp++; if (bus.ill_cnt !== 16'd0) begin n_mis++; $display("FAIL ill_cnt0: got %0h exp 0", bus.ill_cnt); end
        step();
        bus.in_valid = 1'b0;
        n_cmp++; if (bus.out_fmt !== 3'd7 || bus.out_imm !== 64'd0) begin n_mis++; $display("FAIL ill_second: got %0h/%0h exp 7/0", bus.out_fmt, bus.out_imm); end
        n_cmp++; if (bus.ill_cnt !== 16'd1) begin n_mis++; $display("FAIL ill_cnt1: got %0h exp 1", bus.ill_cnt); end
        step();
        n_cmp++; if (bus.ill_cnt !== 16'd2) begin n_mis++; $display("FAIL ill_cnt2: got %0h exp 2", bus.ill_cnt); end
        n_cmp++; if (bus.ill_seen !== 1'b1) begin n_mis++; $display("FAIL ill_seen: got %0h exp 1", bus.ill_seen); end
        flush = 1'b1;
        step();
        flush = 1'b0;
        n_cmp++; if (bus.ill_cnt !== 16'd2 || bus.ill_seen !== 1'b1) begin n_mis++; $display("FAIL ill_after_flush: got %0h/%0h exp 2/1", bus.ill_cnt, bus.ill_seen); end
    endtask
`endif

    initial begin
        n_cmp = 0;
        n_mis = 0;
        test_reset();
        test_addi();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
`ifdef IMM_GEN_ILLEGAL_TRAP_EN
        test_illegal();
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
